// File: rtl/spm_driver_pkg.sv
// spm_driver_pkg
// Shared definitions for the spm operand sequencer:
//   - state_t  : sequencer FSM states (IDLE, CLR, SHIFT, DONE)
//   - SPM_SIZE : default operand width of the spm macro
//   - SPM_P_LAT: default y-to-p latency of the spm macro
package spm_driver_pkg;

  localparam int SPM_SIZE  = 32;
  localparam int SPM_P_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/spm_driver_capture.sv
// spm_driver_capture
// Shift-in deserializer for the serial product stream. Bits arrive LSB first
// and are inserted at the MSB with a right shift, so after W enabled shifts
// the first bit received sits at bit 0.
// Ports:
//   clk      in  1  clock
//   rst      in  1  asynchronous active-low reset (clears the product)
//   clr      in  1  synchronous clear of the product register
//   shift_en in  1  shift din into the MSB this cycle
//   din      in  1  serial product bit
//   prod     out W  parallel product
module spm_driver_capture #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] prod
);

  logic [W-1:0] prod_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_reg <= '0;
    end else if (clr) begin
      prod_reg <= '0;
    end else if (shift_en) begin
      prod_reg <= {din, prod_reg[W-1:1]};
    end
  end

  assign prod = prod_reg;

endmodule

// File: rtl/spm_driver.sv
// spm_driver
// Operand sequencer for one spm serial-parallel multiplier. Accepts an operand
// pair over valid/ready, clears the spm, holds the multiplicand on x, shifts
// the (width-extended) multiplier LSB-first onto y, and reassembles the serial
// product into a 2*SIZE-bit result offered over valid/ready.
// Build option: define SPM_DRIVER_SIGNED_EN to sign-extend the multiplier
// (two's-complement product); otherwise it is zero-extended (unsigned).
// Ports:
//   clk       in  1       clock
//   rst       in  1       asynchronous active-low reset
//   in_valid  in  1       operand pair valid
//   in_ready  out 1       operand pair can be accepted (IDLE only)
//   in_a      in  SIZE    multiplicand, driven onto spm_x
//   in_b      in  SIZE    multiplier, serialised onto spm_y
//   out_valid out 1       product valid (DONE)
//   out_ready in  1       consumer takes product
//   out_prod  out 2*SIZE  product
//   busy      out 1       any state other than IDLE
//   spm_rst   out 1       active-high clear to spm
//   spm_x     out SIZE    parallel operand to spm
//   spm_y     out 1       serial operand to spm
//   spm_p     in  1       serial product from spm
module spm_driver
  import spm_driver_pkg::*;
#(
  parameter int SIZE  = SPM_SIZE,
  parameter int P_LAT = SPM_P_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_a,
  input  logic [SIZE-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_prod,
  output logic              busy,
  output logic              spm_rst,
  output logic [SIZE-1:0]   spm_x,
  output logic              spm_y,
  input  logic              spm_p
);

  localparam int PW   = 2 * SIZE;
  localparam int NCYC = PW + P_LAT;
  localparam int CW   = $clog2(NCYC);
  localparam int IW   = $clog2(PW);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);
  localparam logic [CW-1:0] CNT_PW   = CW'(PW);
  localparam logic [CW-1:0] CNT_PLAT = CW'(P_LAT);

  state_t          state_reg;
  state_t          state_next;
  logic [SIZE-1:0] a_reg;
  logic [SIZE-1:0] b_reg;
  logic [CW-1:0]   cnt_reg;
  logic [PW-1:0]   b_ext;
  logic            ext_bit;
  logic            accept;
  logic            cap_en;

  // Upper half of the serialised multiplier: sign copies or zeros.
`ifdef SPM_DRIVER_SIGNED_EN
  assign ext_bit = b_reg[SIZE-1];
`else
  assign ext_bit = 1'b0;
`endif

  assign b_ext[SIZE-1:0] = b_reg;
  for (genvar gi = SIZE; gi < PW; gi++) begin : g_ext
    assign b_ext[gi] = ext_bit;
  end

  assign accept = (state_reg == IDLE) && in_valid;

  // Product bit k appears on spm_p P_LAT cycles after y bit k was driven,
  // so capture starts once cnt reaches P_LAT and runs for exactly PW bits.
  assign cap_en = (state_reg == SHIFT) && (cnt_reg >= CNT_PLAT);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)             state_next = CLR;
      CLR:                               state_next = SHIFT;
      SHIFT:   if (cnt_reg == CNT_LAST)  state_next = DONE;
      DONE:    if (out_ready)            state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Output decode; reset is folded in so the spm stays cleared and no
  // operand is offered while rst is held low.
  always_comb begin
    in_ready  = rst && (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
    spm_rst   = !rst || (state_reg == CLR);
    spm_y     = 1'b0;
    if ((state_reg == SHIFT) && (cnt_reg < CNT_PW)) begin
      spm_y = b_ext[cnt_reg[IW-1:0]];
    end
  end

  // Operand registers and bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      cnt_reg <= '0;
    end else begin
      if (accept) begin
        a_reg <= in_a;
        b_reg <= in_b;
      end
      if (state_reg == CLR) begin
        cnt_reg <= '0;
      end else if ((state_reg == SHIFT) && (cnt_reg != CNT_LAST)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign spm_x = a_reg;

  spm_driver_capture #(
    .W(PW)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .shift_en (cap_en),
    .din      (spm_p),
    .prod     (out_prod)
  );

endmodule

// File: tb/tb_spm_driver.sv
// tb_spm_driver
// Directed bench: spm_driver (SIZE=32, P_LAT=1) paired with a behavioural
// serial-parallel multiplier. Define SPM_DRIVER_SIGNED_EN for the signed build.
module tb_spm_driver;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;
  logic        busy;
  logic        spm_rst;
  logic [31:0] spm_x;
  logic        spm_y;
  logic        spm_p;

  int n_err = 0;
  int n_chk = 0;

  spm_driver dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy),
    .spm_rst   (spm_rst),
    .spm_x     (spm_x),
    .spm_y     (spm_y),
    .spm_p     (spm_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural spm: accumulates y_k * x * 2^k and emits bit k one cycle
  // after y bit k is presented.
  logic [63:0] m_acc;
  logic [6:0]  m_k;
  logic        m_p;
  logic [63:0] m_xe;
  logic [63:0] m_nxt;
  logic        m_pn;

  always_comb begin
`ifdef SPM_DRIVER_SIGNED_EN
    m_xe = {{32{spm_x[31]}}, spm_x};
`else
    m_xe = {32'd0, spm_x};
`endif
    m_nxt = m_acc;
    m_pn  = 1'b0;
    if (m_k < 7'd64) begin
      m_nxt = m_acc + (spm_y ? (m_xe << m_k[5:0]) : 64'd0);
      m_pn  = m_nxt[m_k[5:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (spm_rst) begin
      m_acc <= '0;
      m_k   <= '0;
      m_p   <= 1'b0;
    end else begin
      m_acc <= m_nxt;
      m_p   <= m_pn;
      if (m_k < 7'd64) m_k <= m_k + 7'd1;
    end
  end

  assign spm_p = m_p;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a pair at a negedge once in_ready is seen; returns just after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  // Called just after an accept edge: counts edges until out_valid and spm_rst cycles.
  task automatic wait_valid(output int lat, output int clr);
    lat = 0;
    clr = 0;
    @(negedge clk);
    while (!out_valid && lat < 300) begin
      if (spm_rst) clr++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                    input string tag);
    int lat;
    int clr;
    send(a, b);
    wait_valid(lat, clr);
    $display("op %s: a=%h b=%h prod=%h latency=%0d", tag, a, b, out_prod, lat);
    chk({tag, "_latency"}, 64'(lat), 64'd66);
    chk({tag, "_spm_rst_cycles"}, 64'(clr), 64'd1);
    chk({tag, "_prod"}, out_prod, exp);
    @(negedge clk);
    chk({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    int clr;
    int saw;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_spm_rst", {63'd0, spm_rst}, 64'd1);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_spm_x", {32'd0, spm_x}, 64'd0);
    chk("rst_spm_y", {63'd0, spm_y}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    $display("reset released: in_ready=%b out_valid=%b out_prod=%h", in_ready, out_valid, out_prod);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("post_rst_out_prod", out_prod, 64'd0);
    chk("post_rst_spm_rst", {63'd0, spm_rst}, 64'd0);

    // Basic products with out_ready tied high
    out_ready = 1'b1;
    op(32'd3, 32'd5, 64'd15, "3x5");
`ifdef SPM_DRIVER_SIGNED_EN
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, "m1xm1");
    op(32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFFFFFFFFFA, "m2x3");
`else
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "ffxff");
    op(32'hFFFFFFFE, 32'h00000003, 64'h00000002FFFFFFFA, "fex3");
`endif

    // Backpressure in DONE with a new pair waiting
    out_ready = 1'b0;
    send(32'd6, 32'd7);
    wait_valid(lat, clr);
    chk("bp_latency", 64'(lat), 64'd66);
    in_valid = 1'b1;
    in_a     = 32'd2;
    in_b     = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      $display("backpressure cycle %0d: out_valid=%b out_prod=%h in_ready=%b", i, out_valid, out_prod, in_ready);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_out_prod", out_prod, 64'd42);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_after_hs_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 32'hDEADBEEF;
    in_b     = 32'hCAFEF00D;
    chk("bp_next_busy", {63'd0, busy}, 64'd1);
    wait_valid(lat, clr);
    $display("op after backpressure: prod=%h latency=%0d", out_prod, lat);
    chk("bp_next_latency", 64'(lat), 64'd66);
    chk("bp_next_prod", out_prod, 64'd6);
    chk("bp_next_spm_x", {32'd0, spm_x}, 64'd2);

    // Reset pulsed while cnt = 20 in SHIFT
    send(32'h00001234, 32'h00005678);
    repeat (21) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    $display("mid-op reset: busy=%b in_ready=%b spm_rst=%b out_valid=%b", busy, in_ready, spm_rst, out_valid);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("midrst_spm_rst", {63'd0, spm_rst}, 64'd1);
    chk("midrst_out_prod", out_prod, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    saw = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    chk("midrst_no_valid", 64'(saw), 64'd0);
    op(32'd7, 32'd9, 64'd63, "7x9");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
